reg_file_mp: RTL
================

Name: reg_file_mp

Overview:
- Parametrised multi-port successor to the lab ARM register file.
- Holds NUM_REGS general registers (R0..R14 by default); read address 15 returns the externally supplied PC+8 value on R15.
- Adds reset clearing, a third read port (register-shifted operands / STR data), and a second write port for load/base-writeback.
- Adds optional same-cycle write-to-read bypass, and a per-register busy scoreboard for multi-cycle producers.
- Sits between decoder/Extend and the ALU/MCycle in the single-cycle/extended CPU datapath.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 4, register address width.
- NUM_REGS, 15, stored registers; must be < 2**ADDR_W. Address NUM_REGS is the PC alias; addresses above it read 0.
- BYPASS, 1, 1 = write data forwarded combinationally to same-cycle reads; 0 = reads return stored value only.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- A1, A2, A5  in  ADDR_W  read addresses, ports 1/2/3.
- RD1, RD2, RD3  out  DATA_W  read data for A1/A2/A5.
- R15  in  DATA_W  PC+8 value returned when a read address == NUM_REGS.
- WE3  in  1  write enable, primary port (ALU result).
- A3  in  ADDR_W  write address, primary port.
- WD3  in  DATA_W  write data, primary port.
- WE4  in  1  write enable, secondary port (load data / long-latency writeback).
- A4  in  ADDR_W  write address, secondary port.
- WD4  in  DATA_W  write data, secondary port.
- SB_SET  in  1  mark register SB_A busy (multi-cycle op issued).
- SB_A  in  ADDR_W  scoreboard set address.
- BUSY1, BUSY2, BUSY3  out  1  busy status of A1/A2/A5.

Behaviour:
- Reset:
  - RESET high asynchronously clears all NUM_REGS registers to 0 and all busy bits to 0, and holds them while asserted.
  - Outputs are combinational, so during reset RDn = 0 for general addresses and R15 for address NUM_REGS; BUSYn = 0.
- Write timing: writes commit at the rising CLK edge and are visible via the bank on the next cycle (one-cycle write latency).
- Ignored writes: a write with address >= NUM_REGS is ignored; the PC is owned by the fetch stage.
- Dual write, same address: both WE3 and WE4 to the same address in one cycle → WD3 is stored; WD4 is dropped.
- Dual write, different addresses: both commit in the same edge.
- Read mux, per port, in priority order:
  - address == NUM_REGS → R15.
  - address > NUM_REGS → 0.
  - BYPASS=1 and WE3 and A3 == address → WD3.
  - BYPASS=1 and WE4 and A4 == address → WD4.
  - otherwise the stored value.
- Read ports are independent; any combination of addresses, including all three equal, is legal.
- Scoreboard, one busy bit per stored register:
  - Set at the edge when SB_SET=1 and SB_A < NUM_REGS.
  - Cleared at the edge when WE4=1 writes that register. WE3 writes do not clear busy.
  - Same register set and cleared in one cycle → set wins, since a new producer has issued.
  - SB_SET to an address >= NUM_REGS is ignored.
- BUSY outputs:
  - BUSYn = busy[An] for An < NUM_REGS, else 0.
  - When BYPASS=1 and WE4 is writing An this cycle, BUSYn = 0, so the consumer may take the forwarded data.
  - When BYPASS=0, BUSYn stays 1 until the cycle after the clearing write.
- Mid-operation reset: busy bits and data clear immediately; any in-flight WE4 arriving after reset writes normally.
- No X propagation: every output is defined for every address value.

Decomposition:
- Shared package (cpu_pkg):
  - DATA_W/ADDR_W defaults.
  - PC_IDX constant (15).
  - Register-index localparams (SP=13, LR=14, PC=15).
- Sub-module rf_read_port:
  - Contains the per-port address compare, bypass priority mux, R15 alias and BUSY logic.
  - Instantiated three times inside reg_file_mp.
- Bank and scoreboard stay in the top module.

Test Plan:
- Reset: write R3=0x1234 via WE3, assert RESET mid-cycle → RD1 (A1=3) reads 0 immediately; BUSY1=0.
- Basic write/read and bypass:
  - With BYPASS=1: WE3, A3=5, WD3=0xDEADBEEF, A1=5 in the same cycle → RD1=0xDEADBEEF that cycle; next cycle with WE3=0, RD1 still 0xDEADBEEF.
  - Repeat with BYPASS=0 → RD1=old value (0) in the write cycle and 0xDEADBEEF after the edge.
- PC alias: R15=0x00000108, A2=15 → RD2=0x108. WE3, A3=15, WD3=0xFFFF → ignored; R0..R14 unchanged; RD2 still follows R15.
- Dual-write conflict:
  - WE3/WE4 both to A=7 with WD3=0x11, WD4=0x22 → RD3 (A5=7) = 0x11 next cycle.
  - Both to A=7 and A=8 → R7=0x11, R8=0x22.
- Scoreboard:
  - SB_SET, SB_A=4 → BUSY1 (A1=4) = 1 next cycle.
  - WE4, A4=4, WD4=0x99 → BUSY1=0 and RD1=0x99 that cycle (BYPASS=1).
  - SB_SET to 4 together with WE4 to 4 → BUSY stays 1.
- Out-of-range: with NUM_REGS=15, A1=15 → R15; all three read ports at A=2 simultaneously return identical data.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and the read-port source selector.
`default_nettype none

package cpu_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 4;

  localparam int PC_IDX = 15;
  localparam int REG_SP = 13;
  localparam int REG_LR = 14;
  localparam int REG_PC = 15;

  typedef enum logic [2:0] {
    SRC_BANK = 3'd0,
    SRC_PC   = 3'd1,
    SRC_ZERO = 3'd2,
    SRC_WD3  = 3'd3,
    SRC_WD4  = 3'd4
  } rd_src_e;

endpackage

`default_nettype wire

// File: rtl/rf_read_port.sv
// One register-file read port: PC alias, out-of-range zero, write bypass and busy view.
`default_nettype none

module rf_read_port
  import cpu_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_REGS = PC_IDX,
  parameter int BYPASS   = 1
) (
  input  logic [ADDR_W-1:0]                addr_i,
  input  logic [NUM_REGS-1:0][DATA_W-1:0]  bank_i,
  input  logic [NUM_REGS-1:0]              busy_i,
  input  logic [DATA_W-1:0]                pc_i,
  input  logic                             we3_i,
  input  logic [ADDR_W-1:0]                a3_i,
  input  logic [DATA_W-1:0]                wd3_i,
  input  logic                             we4_i,
  input  logic [ADDR_W-1:0]                a4_i,
  input  logic [DATA_W-1:0]                wd4_i,
  output logic [DATA_W-1:0]                rd_o,
  output logic                             busy_o
);

  localparam logic [ADDR_W-1:0] C_PC_ADDR = ADDR_W'(NUM_REGS);

  rd_src_e             w_src;
  logic [DATA_W-1:0]   w_stored;
  logic                w_stored_busy;
  logic                w_we3_fwd;
  logic                w_we4_fwd;

  assign w_we3_fwd = (BYPASS != 0) && we3_i && (a3_i == addr_i);
  assign w_we4_fwd = (BYPASS != 0) && we4_i && (a4_i == addr_i);

  // Explicit compare loop keeps the lookup in range for every address value.
  always_comb begin
    w_stored      = '0;
    w_stored_busy = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr_i == ADDR_W'(i)) begin
        w_stored      = bank_i[i];
        w_stored_busy = busy_i[i];
      end
    end
  end

  always_comb begin
    w_src = SRC_BANK;
    if (addr_i == C_PC_ADDR) begin
      w_src = SRC_PC;
    end else if (addr_i > C_PC_ADDR) begin
      w_src = SRC_ZERO;
    end else if (w_we3_fwd) begin
      w_src = SRC_WD3;
    end else if (w_we4_fwd) begin
      w_src = SRC_WD4;
    end
  end

  always_comb begin
    rd_o = w_stored;
    case (w_src)
      SRC_PC:   rd_o = pc_i;
      SRC_ZERO: rd_o = '0;
      SRC_WD3:  rd_o = wd3_i;
      SRC_WD4:  rd_o = wd4_i;
      default:  rd_o = w_stored;
    endcase
  end

  // A landing long-latency result releases the consumer in the same cycle.
  assign busy_o = w_stored_busy & ~w_we4_fwd;

endmodule

`default_nettype wire

// File: rtl/reg_file_mp.sv
// Multi-port ARM register file: 3 reads, 2 writes, R15 alias, optional bypass, busy scoreboard.
`default_nettype none

module reg_file_mp
  import cpu_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_REGS = PC_IDX,
  parameter int BYPASS   = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  input  logic [ADDR_W-1:0] A5,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic [DATA_W-1:0] RD3,
  input  logic [DATA_W-1:0] R15,
  input  logic              WE3,
  input  logic [ADDR_W-1:0] A3,
  input  logic [DATA_W-1:0] WD3,
  input  logic              WE4,
  input  logic [ADDR_W-1:0] A4,
  input  logic [DATA_W-1:0] WD4,
  input  logic              SB_SET,
  input  logic [ADDR_W-1:0] SB_A,
  output logic              BUSY1,
  output logic              BUSY2,
  output logic              BUSY3
);

  logic [NUM_REGS-1:0][DATA_W-1:0] bank_q, bank_d;
  logic [NUM_REGS-1:0]             busy_q, busy_d;

  // WE3 is applied last so it wins a same-address collision with WE4;
  // SB_SET is applied last so a fresh issue wins over a clearing writeback.
  always_comb begin
    bank_d = bank_q;
    busy_d = busy_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (WE4 && (A4 == ADDR_W'(i))) begin
        bank_d[i] = WD4;
        busy_d[i] = 1'b0;
      end
      if (WE3 && (A3 == ADDR_W'(i))) begin
        bank_d[i] = WD3;
      end
      if (SB_SET && (SB_A == ADDR_W'(i))) begin
        busy_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      bank_q <= '0;
      busy_q <= '0;
    end else begin
      bank_q <= bank_d;
      busy_q <= busy_d;
    end
  end

  rf_read_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .BYPASS(BYPASS)
  ) u_rd1 (
    .addr_i(A1), .bank_i(bank_q), .busy_i(busy_q), .pc_i(R15),
    .we3_i(WE3), .a3_i(A3), .wd3_i(WD3),
    .we4_i(WE4), .a4_i(A4), .wd4_i(WD4),
    .rd_o(RD1), .busy_o(BUSY1)
  );

  rf_read_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .BYPASS(BYPASS)
  ) u_rd2 (
    .addr_i(A2), .bank_i(bank_q), .busy_i(busy_q), .pc_i(R15),
    .we3_i(WE3), .a3_i(A3), .wd3_i(WD3),
    .we4_i(WE4), .a4_i(A4), .wd4_i(WD4),
    .rd_o(RD2), .busy_o(BUSY2)
  );

  rf_read_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .BYPASS(BYPASS)
  ) u_rd3 (
    .addr_i(A5), .bank_i(bank_q), .busy_i(busy_q), .pc_i(R15),
    .we3_i(WE3), .a3_i(A3), .wd3_i(WD3),
    .we4_i(WE4), .a4_i(A4), .wd4_i(WD4),
    .rd_o(RD3), .busy_o(BUSY3)
  );

endmodule

`default_nettype wire
